cg_read_sequencer: RTL and testbench

- Front-end address/enable sequencer for the CG datapath (main_alu).
- Per CG iteration, streams cluster read addresses to memories A/P/R/X in three passes:
  - pass 1: mXv1
  - pass 2: update
  - pass 3: rKold_prev capture
- Advances between passes on the ALU's read_again / read_again_2 / finish_iteration handshakes.
- Drives memoryR_read_address and memoryRprev_we into the ALU wrapper; stops on finish or on the iteration limit.

---
 rtl/cg_pkg.sv | 43 ++++
 rtl/cg_read_sequencer_if.sv | 50 +++++
 rtl/cg_addr_counter.sv | 48 ++++
 rtl/cg_read_sequencer.sv | 159 +++++++++++++++
 tb/tb_cg_read_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cg_pkg.sv
// -----------------------------------------------------------------------------
// cg_pkg
// Shared definitions for the CG read sequencer slice: FSM state encoding,
// pass_id codes, default sizing parameters and a small state-to-pass_id
// decoder used by the top level.
// No ports (package).
// -----------------------------------------------------------------------------
package cg_pkg;

    localparam int DEFAULT_NUMBER_OF_CLUSTERS        = 40;
    localparam int DEFAULT_MEMORY_READ_ADDRESS_WIDTH = 20;
    localparam int DEFAULT_ITERATION_WIDTH           = 16;
    localparam int DEFAULT_MAX_ITERATIONS            = 1000;

    // 3-bit state encoding, also exported on the debug port.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PASS1   = 3'd1,
        S_WAIT1   = 3'd2,
        S_PASS2   = 3'd3,
        S_WAIT2   = 3'd4,
        S_PASS3   = 3'd5,
        S_WAIT_IT = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [1:0] PASS_ID_NONE = 2'd0;
    localparam logic [1:0] PASS_ID_1    = 2'd1;
    localparam logic [1:0] PASS_ID_2    = 2'd2;
    localparam logic [1:0] PASS_ID_3    = 2'd3;

    // Only the three streaming states carry a non-zero pass id; waits,
    // idle and done all report 0.
    function automatic logic [1:0] pass_id_of(input state_t s);
        case (s)
            S_PASS1: return PASS_ID_1;
            S_PASS2: return PASS_ID_2;
            S_PASS3: return PASS_ID_3;
            default: return PASS_ID_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cg_read_sequencer_if.sv
// -----------------------------------------------------------------------------
// cg_read_sequencer_if
// Bundles the control handshakes from the ALU and the read-side outputs of
// the sequencer.
//   slave  modport : the sequencer (consumes start/handshakes, drives bus)
//   master modport : the ALU wrapper / environment
// Signals:
//   start_cg, read_again, read_again_2, finish_iteration, finish : in pulses
//   memoryR_read_address, mem_re, memoryRprev_we, pass_id,
//   iteration_count, busy, done, state_dbg                        : outputs
//
// Handshake semantics: every control input is a single-cycle pulse sampled
// on the rising clock edge; there is no valid/ready back-pressure. A pulse
// is acted on only in the state that expects it (or latched as pending while
// the matching pass is still streaming) and is otherwise dropped.
// -----------------------------------------------------------------------------
interface cg_read_sequencer_if #(
    parameter int memory_read_address_width = cg_pkg::DEFAULT_MEMORY_READ_ADDRESS_WIDTH,
    parameter int iteration_width           = cg_pkg::DEFAULT_ITERATION_WIDTH
);
    import cg_pkg::*;

    logic                                 start_cg;
    logic                                 read_again;
    logic                                 read_again_2;
    logic                                 finish_iteration;
    logic                                 finish;

    logic [memory_read_address_width-1:0] memoryR_read_address;
    logic                                 mem_re;
    logic                                 memoryRprev_we;
    logic [1:0]                           pass_id;
    logic [iteration_width-1:0]           iteration_count;
    logic                                 busy;
    logic                                 done;
    state_t                               state_dbg;

    modport slave (
        input  start_cg, read_again, read_again_2, finish_iteration, finish,
        output memoryR_read_address, mem_re, memoryRprev_we, pass_id,
               iteration_count, busy, done, state_dbg
    );

    modport master (
        output start_cg, read_again, read_again_2, finish_iteration, finish,
        input  memoryR_read_address, mem_re, memoryRprev_we, pass_id,
               iteration_count, busy, done, state_dbg
    );

endinterface

// File: rtl/cg_addr_counter.sv
// -----------------------------------------------------------------------------
// cg_addr_counter
// Cluster address counter shared by all three read passes.
// Ports:
//   clk, reset (sync, active-low)
//   clear  : load 0 (wins over enable)
//   enable : increment by one
//   count  : current address
//   tc     : count is at the last cluster (number_of_clusters-1)
// -----------------------------------------------------------------------------
module cg_addr_counter #(
    parameter int number_of_clusters = cg_pkg::DEFAULT_NUMBER_OF_CLUSTERS,
    parameter int width              = cg_pkg::DEFAULT_MEMORY_READ_ADDRESS_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [width-1:0] count,
    output logic             tc
);

    localparam logic [width-1:0] LAST = width'(number_of_clusters - 1);

    logic [width-1:0] count_q;
    logic [width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == LAST);

endmodule

// File: rtl/cg_read_sequencer.sv
// -----------------------------------------------------------------------------
// cg_read_sequencer
// Per CG iteration, streams cluster addresses 0..number_of_clusters-1 to the
// A/P/R/X memories in three passes (mXv1, update, rKold_prev capture),
// advancing between passes on the ALU handshakes and stopping on finish or
// on the iteration limit.
// Ports:
//   clk   : clock
//   reset : synchronous, active-low
//   bus   : cg_read_sequencer_if.slave (handshakes in, read bus/status out)
// -----------------------------------------------------------------------------
module cg_read_sequencer
    import cg_pkg::*;
#(
    parameter int number_of_clusters        = DEFAULT_NUMBER_OF_CLUSTERS,
    parameter int memory_read_address_width = DEFAULT_MEMORY_READ_ADDRESS_WIDTH,
    parameter int iteration_width           = DEFAULT_ITERATION_WIDTH,
    parameter int max_iterations            = DEFAULT_MAX_ITERATIONS
) (
    input logic                  clk,
    input logic                  reset,
    cg_read_sequencer_if.slave   bus
);

    localparam logic [iteration_width-1:0] MAX_IT = iteration_width'(max_iterations);

    state_t                               state_q, state_d;
    logic                                 pend1_q, pend1_d;
    logic                                 pend2_q, pend2_d;
    logic                                 pend3_q, pend3_d;
    logic [iteration_width-1:0]           iter_q, iter_d;
    logic [iteration_width-1:0]           iter_inc;
    logic [1:0]                           pass_id_q, pass_id_d;
    logic                                 we_q, we_d;

    logic                                 in_pass;
    logic                                 cnt_clear;
    logic                                 cnt_enable;
    logic                                 cnt_tc;
    logic [memory_read_address_width-1:0] cnt_value;

    assign in_pass = (state_q == S_PASS1) || (state_q == S_PASS2) ||
                     (state_q == S_PASS3);

    // Saturating increment; unreachable while max_iterations fits the width.
    assign iter_inc = (iter_q == '1) ? iter_q : iter_q + iteration_width'(1);

    always_comb begin
        state_d    = state_q;
        pend1_d    = pend1_q;
        pend2_d    = pend2_q;
        pend3_d    = pend3_q;
        iter_d     = iter_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_cg) begin
                    state_d = S_PASS1;
                    iter_d  = '0;
                end
            end
            S_PASS1: begin
                if (bus.read_again) pend1_d = 1'b1;
                if (cnt_tc)         state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (bus.read_again || pend1_q) begin
                    state_d = S_PASS2;
                    pend1_d = 1'b0;
                end
            end
            S_PASS2: begin
                if (bus.read_again_2) pend2_d = 1'b1;
                if (cnt_tc)           state_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (bus.read_again_2 || pend2_q) begin
                    state_d = S_PASS3;
                    pend2_d = 1'b0;
                end
            end
            S_PASS3: begin
                if (bus.finish_iteration) pend3_d = 1'b1;
                if (cnt_tc)               state_d = S_WAIT_IT;
            end
            S_WAIT_IT: begin
                if (bus.finish_iteration || pend3_q) begin
                    pend3_d = 1'b0;
                    iter_d  = iter_inc;
                    state_d = (iter_inc == MAX_IT) ? S_DONE : S_PASS1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Convergence overrides everything decided above, including an
        // iteration increment from a simultaneous finish_iteration.
        if (bus.finish && (state_q != S_IDLE)) begin
            state_d = S_DONE;
            iter_d  = iter_q;
            pend1_d = 1'b0;
            pend2_d = 1'b0;
            pend3_d = 1'b0;
        end

        // Restart the address on entry to any pass and park it at 0 in DONE;
        // entering a WAIT leaves the last address on the bus.
        cnt_clear  = (state_d != state_q) &&
                     ((state_d == S_PASS1) || (state_d == S_PASS2) ||
                      (state_d == S_PASS3) || (state_d == S_DONE));
        cnt_enable = in_pass && !cnt_tc;

        // rKold_prev write trails the pass-3 read by the memory latency.
        we_d      = (state_q == S_PASS3);
        pass_id_d = pass_id_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pend1_q   <= 1'b0;
            pend2_q   <= 1'b0;
            pend3_q   <= 1'b0;
            iter_q    <= '0;
            pass_id_q <= PASS_ID_NONE;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend1_q   <= pend1_d;
            pend2_q   <= pend2_d;
            pend3_q   <= pend3_d;
            iter_q    <= iter_d;
            pass_id_q <= pass_id_d;
            we_q      <= we_d;
        end
    end

    cg_addr_counter #(
        .number_of_clusters (number_of_clusters),
        .width              (memory_read_address_width)
    ) u_addr_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (cnt_value),
        .tc     (cnt_tc)
    );

    assign bus.memoryR_read_address = cnt_value;
    assign bus.mem_re               = in_pass;
    assign bus.memoryRprev_we       = we_q;
    assign bus.pass_id              = pass_id_q;
    assign bus.iteration_count      = iter_q;
    assign bus.busy                 = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done                 = (state_q == S_DONE);
    assign bus.state_dbg            = state_q;

endmodule

// File: tb/tb_cg_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cg_read_sequencer
// Self-checking bench for cg_read_sequencer. Each scenario fills per-cycle
// handshake pulse tables, a pass-level reference model turns those tables
// into expected per-cycle outputs, and the run window drives the pulses and
// compares the DUT cycle by cycle. memoryRprev_we pulses are additionally
// matched against a queue of expected pass-3 addresses.
// -----------------------------------------------------------------------------
module tb_cg_read_sequencer;
    import cg_pkg::*;

    localparam int N     = 40;
    localparam int AW    = 20;
    localparam int IW    = 16;
    localparam int MAXIT = 2;
    localparam int MAXT  = 512;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cg_read_sequencer_if #(.memory_read_address_width(AW), .iteration_width(IW)) bus ();

    cg_read_sequencer #(
        .number_of_clusters        (N),
        .memory_read_address_width (AW),
        .iteration_width           (IW),
        .max_iterations            (MAXIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Stimulus tables, indexed by cycle offset from the first PASS1 cycle.
    bit ra_a  [MAXT];
    bit ra2_a [MAXT];
    bit fi_a  [MAXT];
    bit fin_a [MAXT];

    // Expected outputs per cycle.
    logic [AW-1:0] exp_addr [MAXT];
    bit            exp_re   [MAXT];
    logic [1:0]    exp_pid  [MAXT];
    bit            exp_we   [MAXT];
    logic [IW-1:0] exp_it   [MAXT];
    bit            exp_busy [MAXT];
    bit            exp_done [MAXT];
    logic [AW-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.start_cg         = 1'b0;
        bus.read_again       = 1'b0;
        bus.read_again_2     = 1'b0;
        bus.finish_iteration = 1'b0;
        bus.finish           = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic start_pulse();
        bus.start_cg = 1'b1;
        tick();
        bus.start_cg = 1'b0;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXT; i++) begin
            ra_a[i] = 0; ra2_a[i] = 0; fi_a[i] = 0; fin_a[i] = 0;
        end
    endtask

    // Places one handshake per pass. mode 0: random early/late plus stray
    // pulses of the other handshakes; mode 1: 5 cycles after the pass ends;
    // mode 2: on the first wait cycle. early_at >= 0 forces the first
    // read_again onto that pass-1 address.
    task automatic gen_handshakes(input int n_iter, input int mode,
                                  input int early_at, output int t_next);
        int s;
        int h;
        s = 0;
        for (int it = 0; it < n_iter; it++) begin
            for (int k = 1; k <= 3; k++) begin
                case (mode)
                    0: h = ($urandom_range(0, 1) == 1) ? s + int'($urandom_range(0, N - 1))
                                                       : s + N + int'($urandom_range(0, 6));
                    1: h = s + N + 4;
                    default: h = s + N;
                endcase
                if (k == 1 && it == 0 && early_at >= 0) h = s + early_at;
                if (mode == 0 && k == 1) begin
                    ra2_a[s + int'($urandom_range(0, N - 1))] = 1;
                    fi_a[s + int'($urandom_range(0, N - 1))]  = 1;
                end
                if (mode == 0 && k == 2) ra_a[s + int'($urandom_range(0, N - 1))] = 1;
                case (k)
                    1: ra_a[h] = 1;
                    2: ra2_a[h] = 1;
                    default: fi_a[h] = 1;
                endcase
                s = (h < s + N) ? s + N + 1 : h + 1;
            end
        end
        t_next = s;
    endtask

    // ---------------- reference model ----------------
    // Pass-level view: a pass occupies N cycles from its start; its
    // handshake is the first matching pulse at or after that start; a pulse
    // inside the pass is remembered and the next pass starts one cycle after
    // the wait is entered, otherwise one cycle after the pulse. A finish
    // pulse puts everything from the following cycle into DONE.
    task automatic build_expect(input int t_len);
        int s, k, it, done_at, hf, h, nxt;
        s = 0; k = 1; it = 0; hf = -1; done_at = 2 * MAXT;
        exp_q.delete();
        for (int i = 0; i < t_len; i++) if (fin_a[i] && hf < 0) hf = i;
        if (hf >= 0) done_at = hf + 1;
        for (int i = 0; i < MAXT; i++) begin
            exp_addr[i] = AW'(N - 1); exp_re[i] = 0; exp_pid[i] = 2'd0; exp_we[i] = 0;
            exp_it[i] = '0; exp_busy[i] = 1; exp_done[i] = 0;
        end
        while (s < t_len && s < done_at) begin
            for (int j = 0; j < N; j++) begin
                if (s + j < t_len && s + j < done_at) begin
                    exp_re[s + j] = 1; exp_pid[s + j] = 2'(k); exp_addr[s + j] = AW'(j);
                end
            end
            h = -1;
            for (int i = s; i < t_len; i++) begin
                if (h < 0 && ((k == 1 && ra_a[i]) || (k == 2 && ra2_a[i]) || (k == 3 && fi_a[i])))
                    h = i;
            end
            if (h < 0) break;
            nxt = (h < s + N) ? s + N + 1 : h + 1;
            if (k == 3) begin
                if (nxt >= done_at) break;
                it++;
                for (int i = nxt; i < MAXT; i++) exp_it[i] = IW'(it);
                if (it == MAXIT) begin
                    done_at = nxt;
                    break;
                end
            end
            k = (k == 3) ? 1 : k + 1;
            s = nxt;
        end
        for (int i = done_at; i < t_len; i++) begin
            exp_addr[i] = '0; exp_re[i] = 0; exp_pid[i] = 2'd0; exp_busy[i] = 0; exp_done[i] = 1;
        end
        for (int i = 1; i < t_len; i++) begin
            exp_we[i] = exp_re[i - 1] && (exp_pid[i - 1] == 2'd3);
            if (exp_we[i]) exp_q.push_back(exp_addr[i - 1]);
        end
    endtask

    // Drives the pulse tables and scoreboards the DUT for t_len cycles,
    // starting on the first PASS1 cycle.
    task automatic run_window(input string tag, input int t_len);
        logic [AW-1:0] prev_addr;
        logic [AW-1:0] want;
        prev_addr = '0;
        for (int i = 0; i < t_len; i++) begin
            bus.read_again       = ra_a[i];
            bus.read_again_2     = ra2_a[i];
            bus.finish_iteration = fi_a[i];
            bus.finish           = fin_a[i];
            tests_run++;
            if ({bus.memoryR_read_address, bus.mem_re, bus.pass_id, bus.memoryRprev_we,
                 bus.iteration_count, bus.busy, bus.done} !==
                {exp_addr[i], exp_re[i], exp_pid[i], exp_we[i], exp_it[i], exp_busy[i], exp_done[i]}) begin
                tests_failed++;
                $display("FAIL %s cyc=%0d got addr=%0d re=%0b pid=%0d we=%0b it=%0d busy=%0b done=%0b exp addr=%0d re=%0b pid=%0d we=%0b it=%0d busy=%0b done=%0b",
                         tag, i, bus.memoryR_read_address, bus.mem_re, bus.pass_id, bus.memoryRprev_we,
                         bus.iteration_count, bus.busy, bus.done, exp_addr[i], exp_re[i], exp_pid[i],
                         exp_we[i], exp_it[i], exp_busy[i], exp_done[i]);
            end
            if (bus.memoryRprev_we === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s rprev_we cyc=%0d got pulse after addr %0d exp no pulse", tag, i, prev_addr);
                end else begin
                    want = exp_q.pop_front();
                    if (prev_addr !== want) begin
                        tests_failed++;
                        $display("FAIL %s rprev_we cyc=%0d got addr %0d exp addr %0d", tag, i, prev_addr, want);
                    end
                end
            end
            prev_addr = bus.memoryR_read_address;
            tick();
        end
        drive_idle();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s rprev_we_count got %0d missing pulses exp 0", tag, exp_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        bus.start_cg = 1'b1;              // must be ignored while in reset
        reset = 1'b0;
        repeat (3) tick();
        bus.start_cg = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        tests_run += 8;
        if (bus.memoryR_read_address !== '0) begin tests_failed++; $display("FAIL reset_addr got %0d exp 0", bus.memoryR_read_address); end
        if (bus.mem_re !== 1'b0)             begin tests_failed++; $display("FAIL reset_mem_re got %0b exp 0", bus.mem_re); end
        if (bus.memoryRprev_we !== 1'b0)     begin tests_failed++; $display("FAIL reset_we got %0b exp 0", bus.memoryRprev_we); end
        if (bus.pass_id !== 2'd0)            begin tests_failed++; $display("FAIL reset_pass_id got %0d exp 0", bus.pass_id); end
        if (bus.iteration_count !== '0)      begin tests_failed++; $display("FAIL reset_iter got %0d exp 0", bus.iteration_count); end
        if (bus.busy !== 1'b0)               begin tests_failed++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
        if (bus.done !== 1'b0)               begin tests_failed++; $display("FAIL reset_done got %0b exp 0", bus.done); end
        if (bus.state_dbg !== S_IDLE)        begin tests_failed++; $display("FAIL reset_state got %0d exp %0d", bus.state_dbg, S_IDLE); end
        // A stray handshake in IDLE does nothing.
        bus.read_again = 1'b1;
        tick();
        bus.read_again = 1'b0;
        tick();
        tests_run++;
        if (bus.state_dbg !== S_IDLE) begin tests_failed++; $display("FAIL idle_stray_state got %0d exp %0d", bus.state_dbg, S_IDLE); end
        // First pass with no handshakes: 40 addresses then parked in WAIT1.
        clear_stim();
        build_expect(N + 3);
        start_pulse();
        run_window("first_pass", N + 3);
    endtask

    task automatic test_full_iteration();
        int tn;
        do_reset();
        clear_stim();
        gen_handshakes(1, 1, -1, tn);
        build_expect(tn + N + 3);
        start_pulse();
        run_window("full_iteration", tn + N + 3);
    endtask

    task automatic test_early_handshake();
        int tn;
        do_reset();
        clear_stim();
        gen_handshakes(1, 2, 20, tn);
        build_expect(tn + 5);
        start_pulse();
        run_window("early_read_again", tn + 5);
    endtask

    task automatic test_random_iterations();
        int tn;
        int n_iter;
        for (int r = 0; r < 5; r++) begin
            do_reset();
            clear_stim();
            n_iter = int'($urandom_range(1, 2));
            gen_handshakes(n_iter, 0, -1, tn);
            build_expect(tn + N + 3);
            start_pulse();
            run_window("random_iter", tn + N + 3);
        end
    endtask

    task automatic test_finish_with_iteration();
        int tn;
        int h3;
        do_reset();
        clear_stim();
        gen_handshakes(1, 1, -1, tn);
        h3 = 0;
        for (int i = 0; i < MAXT; i++) if (fi_a[i]) h3 = i;
        fin_a[h3] = 1;
        build_expect(h3 + 6);
        start_pulse();
        run_window("finish_with_fi", h3 + 6);
    endtask

    task automatic test_finish_mid_pass();
        int tn;
        int h2;
        int f;
        do_reset();
        clear_stim();
        gen_handshakes(1, 2, -1, tn);
        h2 = 0;
        for (int i = 0; i < MAXT; i++) if (ra2_a[i]) h2 = i;
        f = h2 + 1 + int'($urandom_range(0, N - 1));
        fin_a[f] = 1;
        build_expect(f + 4);
        start_pulse();
        run_window("finish_mid_pass3", f + 4);
    endtask

    task automatic test_max_iterations();
        int tn;
        do_reset();
        clear_stim();
        gen_handshakes(MAXIT, 2, -1, tn);
        build_expect(tn + 5);
        start_pulse();
        run_window("max_iterations", tn + 5);
        // Restart from DONE: count and done must clear, pass 1 from 0.
        clear_stim();
        gen_handshakes(1, 2, -1, tn);
        build_expect(N + 5);
        start_pulse();
        run_window("restart_after_done", N + 5);
    endtask

    task automatic test_reset_mid_pass();
        int tn;
        int p2;
        do_reset();
        clear_stim();
        gen_handshakes(1, 2, -1, tn);
        p2 = N + 1;
        for (int i = 0; i < MAXT; i++) ra2_a[i] = 0;
        ra2_a[p2 + 5] = 1;                // leaves pass-2 pending flag set
        build_expect(p2 + 17);
        start_pulse();
        run_window("pre_reset", p2 + 17);
        tests_run++;
        if (bus.memoryR_read_address !== AW'(17)) begin
            tests_failed++;
            $display("FAIL reset_point_addr got %0d exp 17", bus.memoryR_read_address);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests_run++;
        if ({bus.memoryR_read_address, bus.mem_re, bus.memoryRprev_we, bus.pass_id,
             bus.iteration_count, bus.busy, bus.done} !== '0 || bus.state_dbg !== S_IDLE) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs got addr=%0d re=%0b we=%0b pid=%0d it=%0d busy=%0b done=%0b state=%0d exp all 0 state=%0d",
                     bus.memoryR_read_address, bus.mem_re, bus.memoryRprev_we, bus.pass_id,
                     bus.iteration_count, bus.busy, bus.done, bus.state_dbg, S_IDLE);
        end
        bus.read_again = 1'b1;
        tick();
        bus.read_again = 1'b0;
        tick();
        tests_run++;
        if (bus.state_dbg !== S_IDLE || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_read_again got state=%0d busy=%0b exp state=%0d busy=0", bus.state_dbg, bus.busy, S_IDLE);
        end
        // Late handshakes only: a surviving pending flag would start a pass early.
        clear_stim();
        gen_handshakes(1, 1, -1, tn);
        build_expect(tn + 3);
        start_pulse();
        run_window("after_mid_reset", tn + 3);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_full_iteration();
        test_early_handshake();
        test_random_iterations();
        test_finish_with_iteration();
        test_finish_mid_pass();
        test_max_iterations();
        test_reset_mid_pass();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
